// File: rtl/fc_argmax.sv
// fc_argmax
// ---------
// Picks the largest of N_CLASS unsigned neuron outputs and reports its index
// and value. A vector is captured in one cycle, then scanned one entry per
// cycle. A strict greater-than is used for replacement, so on ties the lowest
// index wins.
//
// Parameters
//   WIDTH    activation width of the upstream layer
//   IN       fan-in of the upstream layer; the neuron width is
//            ZW = 2*WIDTH + clog2(IN)
//   N_CLASS  number of entries compared (2..256)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   z          N_CLASS unsigned entries of ZW bits each
//   in_valid   z is valid this cycle
//   in_ready   block can take z (only in IDLE, and never while rst is high)
//   out_class  index of the maximum entry
//   out_max    value of the maximum entry
//   out_valid  out_class / out_max are valid
//   out_ready  downstream takes the result
//   dbg_state  current FSM state, for debug visibility
//
// Handshake: a transfer happens on a rising edge where both valid and ready
// are high. The producer holds its payload until that edge; ready never
// depends on valid in the same cycle. out_class / out_max keep their last
// value after the transfer; only out_valid qualifies them.

module fc_argmax #(
    parameter  int WIDTH   = 8,
    parameter  int IN      = 128,
    parameter  int N_CLASS = 10,
    localparam int ZW      = WIDTH * 2 + $clog2(IN),
    localparam int IW      = $clog2(N_CLASS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [ZW-1:0] z [0:N_CLASS-1],
    input  logic          in_valid,
    output logic          in_ready,
    output logic [IW-1:0] out_class,
    output logic [ZW-1:0] out_max,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(N_CLASS - 1);

    state_t        state;
    state_t        state_next;
    logic [ZW-1:0] zr [0:N_CLASS-1];
    logic [IW-1:0] idx;
    logic [ZW-1:0] best;
    logic [IW-1:0] best_idx;
    logic          accept;
    logic          take;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    // Strict compare: an equal later entry never displaces an earlier one.
    assign take      = zr[idx] > best;
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)     state_next = SCAN;
            SCAN:    if (idx == LAST)  state_next = DONE;
            DONE:    if (out_ready)    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Payload copy: only ever written on an accepted transfer.
    always_ff @(posedge clk) begin
        if (accept) begin
            zr <= z;
        end
    end

    // Scan datapath and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_class <= '0;
            out_max   <= '0;
            idx       <= '0;
            best      <= '0;
            best_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Entry 0 is the initial candidate; scanning starts at 1.
                        best     <= z[0];
                        best_idx <= '0;
                        idx      <= IW'(1);
                    end
                end
                SCAN: begin
                    if (take) begin
                        best     <= zr[idx];
                        best_idx <= idx;
                    end
                    if (idx == LAST) begin
                        // Fold the last comparison straight into the outputs
                        // so the result is ready on the same edge.
                        out_valid <= 1'b1;
                        out_class <= take ? idx : best_idx;
                        out_max   <= take ? zr[idx] : best;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_argmax.sv
// Testbench for fc_argmax: directed table, multi-cycle corner sequences and
// randomized traffic checked against a reference argmax model.

module tb_fc_argmax;

  localparam int WIDTH   = 8;
  localparam int IN      = 128;
  localparam int N_CLASS = 10;
  localparam int ZW      = WIDTH * 2 + $clog2(IN);
  localparam int IW      = $clog2(N_CLASS);
  localparam int LAT     = N_CLASS - 1;
  localparam int RW      = IW + ZW;

  typedef logic [ZW-1:0] zvec_t [0:N_CLASS-1];

  typedef struct {
    zvec_t         z;
    logic [IW-1:0] cls;
    logic [ZW-1:0] mx;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  zvec_t         z;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] out_class;
  logic [ZW-1:0] out_max;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  fc_argmax #(.WIDTH(WIDTH), .IN(IN), .N_CLASS(N_CLASS)) dut (
    .clk(clk), .rst(rst), .z(z), .in_valid(in_valid), .in_ready(in_ready),
    .out_class(out_class), .out_max(out_max), .out_valid(out_valid),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: find the largest value by sorting, then the first index
  // holding it.
  function automatic logic [RW-1:0] model(input zvec_t v);
    logic [ZW-1:0] q[$];
    logic [ZW-1:0] m;
    int            k;
    foreach (v[i]) q.push_back(v[i]);
    q.rsort();
    m = q[0];
    k = 0;
    for (int i = N_CLASS - 1; i >= 0; i--) if (v[i] == m) k = i;
    return {IW'(k), m};
  endfunction

  function automatic zvec_t rand_vec();
    zvec_t v;
    int    mode;
    mode = $urandom_range(0, 2);
    foreach (v[i]) begin
      case (mode)
        0:       v[i] = ZW'($urandom);
        1:       v[i] = ZW'($urandom_range(0, 3));
        default: v[i] = 23'h7FFFF0 + ZW'($urandom_range(0, 15));
      endcase
    end
    return v;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [RW-1:0] exp_q[$];
  int            acc_q[$];
  logic          prev_ov = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      check("rst_in_ready", in_ready, 1'b0);
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_out: out_valid=1 with no pending vector, required 0 (t=%0t)", $time);
        end else begin
          check("mon_result", {out_class, out_max}, exp_q[0]);
          check("mon_in_ready_done", in_ready, 1'b0);
          if (!prev_ov) check("mon_latency", cyc - acc_q[0], LAT);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(z));
        acc_q.push_back(cyc + 1);
      end
    end
    prev_ov = rst ? 1'b0 : out_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic send_vec(input zvec_t v);
    bit ok;
    @(posedge clk); #1;
    z = v;
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin n_vec++; n_err++; $display("FAIL send_timeout: in_ready=0 required 1"); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) begin n_vec++; n_err++; $display("FAIL out_timeout: out_valid=0 required 1"); end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  vec_t          tbl[8];
  int            basic[10] = '{3, 7, 1, 0, 9, 2, 9, 4, 8, 5};
  bit            ok;
  int            seen;
  int            acc_e[3];
  int            sent;
  bit            acc;
  zvec_t         vb;
  logic [RW-1:0] rb;

  initial begin
    // Vector table
    foreach (basic[j]) tbl[0].z[j] = ZW'(basic[j]);
    tbl[0].cls = 4; tbl[0].mx = 9;
    foreach (tbl[1].z[j]) tbl[1].z[j] = '0;
    tbl[1].cls = 0; tbl[1].mx = 0;
    foreach (tbl[2].z[j]) tbl[2].z[j] = 23'h7FFFFE;
    tbl[2].z[9] = 23'h7FFFFF;
    tbl[2].cls = 9; tbl[2].mx = 23'h7FFFFF;
    foreach (tbl[3].z[j]) tbl[3].z[j] = 23'h7FFFFF;
    tbl[3].cls = 0; tbl[3].mx = 23'h7FFFFF;
    foreach (tbl[4].z[j]) tbl[4].z[j] = ZW'(j + 1);
    tbl[4].z[0] = 100;
    tbl[4].cls = 0; tbl[4].mx = 100;
    foreach (tbl[5].z[j]) tbl[5].z[j] = ZW'(j);
    tbl[5].z[5] = 23'h400000; tbl[5].z[8] = 23'h400000;
    tbl[5].cls = 5; tbl[5].mx = 23'h400000;
    foreach (tbl[6].z[j]) tbl[6].z[j] = 23'h3FFFFF;
    tbl[6].z[3] = 23'h400000;
    tbl[6].cls = 3; tbl[6].mx = 23'h400000;
    foreach (tbl[7].z[j]) tbl[7].z[j] = ZW'(j * 1000);
    tbl[7].cls = 9; tbl[7].mx = 9000;
    z = tbl[1].z;

    // Reset, with in_valid asserted during reset (must not be taken)
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_class", out_class, 0);
    check("reset_out_max", out_max, 0);
    check("reset_in_ready", in_ready, 1'b1);

    // Table-driven vectors
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      send_vec(tbl[i].z);
      wait_out(ok);
      check($sformatf("tbl%0d_class", i), out_class, tbl[i].cls);
      check($sformatf("tbl%0d_max", i), out_max, tbl[i].mx);
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready_after", i), in_ready, 1'b1);
      check($sformatf("tbl%0d_valid_low", i), out_valid, 1'b0);
    end

    // Backpressure: hold 20 cycles, inject ignored in_valid, then one handshake
    out_ready = 1'b0;
    send_vec(tbl[0].z);
    wait_out(ok);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin z = tbl[2].z; in_valid = 1'b1; end
      if (i == 12) in_valid = 1'b0;
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_class", out_class, 4);
      check("bp_max", out_max, 9);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_valid_after", out_valid, 1'b0);
    check("bp_class_kept", out_class, 4);
    check("bp_max_kept", out_max, 9);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("bp_single_handshake", seen, 0);

    // Reset 4 cycles after accept; in_valid high during reset too
    send_vec(tbl[7].z);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    send_vec(tbl[2].z);
    wait_out(ok);
    check("post_abort_class", out_class, 9);
    check("post_abort_max", out_max, 23'h7FFFFF);
    @(posedge clk); #1;

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    in_valid = 1'b1;
    z = rand_vec();
    for (int k = 0; k < 3; k++) begin
      ok = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin n_vec++; n_err++; $display("FAIL b2b_timeout: in_ready=0 required 1"); end
      acc_e[k] = cyc + 1;
      @(posedge clk); #1;
      z = rand_vec();
    end
    in_valid = 1'b0;
    check("b2b_gap01", acc_e[1] - acc_e[0], N_CLASS + 1);
    check("b2b_gap12", acc_e[2] - acc_e[1], N_CLASS + 1);
    drain();

    // Directed model sanity on a random vector with forced tie at the top
    vb = rand_vec();
    vb[2] = 23'h7FFFFF; vb[6] = 23'h7FFFFF;
    rb = model(vb);
    send_vec(vb);
    wait_out(ok);
    check("tie_rand_class", out_class, 2);
    check("tie_rand_model", {out_class, out_max}, rb);
    drain();

    // Randomized valid/ready traffic
    sent = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 60000 && sent < 3000; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        z = rand_vec();
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid = 1'b0;
    check("rand_sent", sent, 3000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
